// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: opcodes, FSM state encoding and
// flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per enabled cycle,
// WIDTH steps per product; done pulses combinationally on the final step.
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic [CNT_W-1:0] cnt;

  // product is the accumulator after the current step, valid when done is high
  assign acc_step = mplier[0] ? (acc + mcand) : acc;
  assign busy     = (cnt != {CNT_W{1'b0}});
  assign done     = enable && busy && (cnt == CNT_W'(1));
  assign product  = acc_step;

  // Operand latch on start, then shift-add iteration until the counter empties
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (enable && start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CNT_W'(WIDTH);
    end else if (enable && busy) begin
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      acc    <= acc_step;
      cnt    <= cnt - CNT_W'(1);
    end else begin
      mcand  <= mcand;
      mplier <= mplier;
      acc    <= acc;
      cnt    <= cnt;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and an iterative multiplier.
// Optional flags output {N,Z,C,V} is built when ALU_FLAGS_EN is defined.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] result_nx;
  logic [WIDTH-1:0] alu_res;
  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign in_ready  = enable && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .start   (mul_start),
    .a       (src1),
    .b       (src2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle datapath for every non-multiply opcode
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src1 + src2;
      OP_SUB:  alu_res = src1 - src2;
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SLL:  alu_res = src1 << src2[SH_W-1:0];
      OP_SRL:  alu_res = src1 >> src2[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic       alu_c;
  logic       alu_v;
  logic [3:0] flags_nx;

  function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == {WIDTH{1'b0}});
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  // Carry is wrap-around for ADD and no-borrow for SUB; V is signed overflow
  always_comb begin
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_ADD: begin
        alu_c = (alu_res < src1);
        alu_v = (src1[WIDTH-1] == src2[WIDTH-1]) && (alu_res[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_c = (src1 >= src2);
        alu_v = (src1[WIDTH-1] != src2[WIDTH-1]) && (alu_res[WIDTH-1] != src1[WIDTH-1]);
      end
      default: begin
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
    endcase
  end
`endif

  // Handshake FSM: next state, result load and multiplier launch
  always_comb begin
    state_nx  = state;
    result_nx = result;
    mul_start = 1'b0;
`ifdef ALU_FLAGS_EN
    flags_nx  = flags;
`endif
    if (enable) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mul_start = 1'b1;
              state_nx  = ST_BUSY;
            end else begin
              result_nx = alu_res;
              state_nx  = ST_DONE;
`ifdef ALU_FLAGS_EN
              flags_nx  = make_flags(alu_res, alu_c, alu_v);
`endif
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = state;
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            result_nx = mul_prod;
            state_nx  = ST_DONE;
`ifdef ALU_FLAGS_EN
            flags_nx  = make_flags(mul_prod, 1'b0, 1'b0);
`endif
          end else if (!mul_busy) begin
            // engine lost its operation: recover instead of waiting forever
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_BUSY;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end else begin
      state_nx = state;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      result <= '0;
`ifdef ALU_FLAGS_EN
      flags  <= 4'b0000;
`endif
    end else begin
      state  <= state_nx;
      result <= result_nx;
`ifdef ALU_FLAGS_EN
      flags  <= flags_nx;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: a transaction-level reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_alu_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
`ifdef ALU_FLAGS_EN
  logic [3:0]   flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef ALU_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour of one operation, from the opcode table
  function automatic logic [W-1:0] ref_alu(input logic [3:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (o)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return a << (b % W);
      4'd7:    return a >> (b % W);
      default: return '0;
    endcase
  endfunction

  // Transaction model: a held result, or a multiply counting down enabled cycles
  logic         m_valid;
  logic         m_busy;
  int           m_left;
  logic [W-1:0] m_result;
  logic [W-1:0] m_pend;
  logic         m_ready;

  assign m_ready = enable && !m_busy && (!m_valid || out_ready);

  always @(posedge clk) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_busy   <= 1'b0;
      m_left   <= 0;
      m_result <= '0;
    end else if (enable) begin
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy   <= 1'b0;
          m_valid  <= 1'b1;
          m_result <= m_pend;
          m_left   <= 0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (in_valid && m_ready) begin
        if (op == 4'd2) begin
          m_busy  <= 1'b1;
          m_valid <= 1'b0;
          m_left  <= W;
          m_pend  <= ref_alu(op, src1, src2);
        end else begin
          m_valid  <= 1'b1;
          m_result <= ref_alu(op, src1, src2);
        end
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("model_out_valid", out_valid, m_valid);
      chk("model_in_ready", in_ready, m_ready);
      chk("model_result", result, m_result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    #1;
    chk("issue_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic alu1(input string name, input logic [3:0] o, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] e);
    issue(o, a, b);
    chk(name, result, e);
    chk({name, "_valid"}, out_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int seen;
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; op = 4'd0;
    tick(); tick();
    checking = 1'b1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    reset = 1'b0;
    tick();
    chk("post_reset_in_ready", in_ready, 1);

    // single ADD then drain to idle
    out_ready = 1'b1;
    alu1("add_10_5", 4'd0, 32'd10, 32'd5, 32'd15);
    tick();
    chk("add_drain_out_valid", out_valid, 0);

    // back-to-back table of single-cycle ops
    alu1("sub_20_10", 4'd1, 32'd20, 32'd10, 32'd10);
`ifdef ALU_FLAGS_EN
    chk("flags_sub_20_10", flags, 4'b0010);
`endif
    alu1("sub_5_10", 4'd1, 32'd5, 32'd10, 32'hFFFF_FFFB);
`ifdef ALU_FLAGS_EN
    chk("flags_sub_5_10", flags, 4'b1000);
`endif
    alu1("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
`ifdef ALU_FLAGS_EN
    chk("flags_add_ovf", flags, 4'b1001);
`endif
    alu1("and", 4'd3, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    alu1("or", 4'd4, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    alu1("xor", 4'd5, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5);
    alu1("sll_masked", 4'd6, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010);
    alu1("srl_31", 4'd7, 32'h8000_0000, 32'd31, 32'h0000_0001);
    tick();

    // backpressure, then replace-on-accept with no bubble
    out_ready = 1'b0;
    alu1("bp_add", 4'd0, 32'd10, 32'd5, 32'd15);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", result, 32'd15);
      chk("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    alu1("bp_sub_no_bubble", 4'd1, 32'd9, 32'd4, 32'd5);
    tick();

    // multiply latency and value
    issue(4'd2, 32'd5, 32'd6);
    n = 0;
    while (!out_valid && n < 100) begin
      chk("mul_in_ready_low", in_ready, 0);
      tick();
      n++;
    end
    chk("mul_latency", n, W);
    chk("mul_5x6", result, 32'd30);
    issue(4'd2, 32'h0000_FFFF, 32'h0001_0001);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("mul_big_latency", n, W);
    chk("mul_big", result, 32'hFFFF_FFFF);

    // reset in the middle of a multiply
    issue(4'd2, 32'd3, 32'd4);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_result", result, 0);
    reset = 1'b0;
    tick();
    chk("rst_mid_in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin tick(); if (out_valid) seen++; end
    chk("aborted_mul_absent", seen, 0);

    // enable freeze during a multiply
    issue(4'd2, 32'd7, 32'd3);
    n = 0;
    repeat (5) begin tick(); n++; end
    enable = 1'b0;
    repeat (4) begin tick(); n++; chk("freeze_in_ready", in_ready, 0); end
    enable = 1'b1;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("freeze_mul_latency", n, W + 4);
    chk("freeze_mul_7x3", result, 32'd21);
    enable = 1'b0;
    tick();
    chk("freeze_hold_valid", out_valid, 1);
    chk("freeze_hold_result", result, 32'd21);
    enable = 1'b1;
    tick();
    chk("freeze_release_drain", out_valid, 0);

    // illegal opcode clears the result with single-cycle latency
    alu1("illegal_op", 4'b1010, 32'd123, 32'd456, 32'd0);
    tick();

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, handshaked successor to the single-cycle ALU plus reg32 operand/result registers. Operands, opcode and result are registered internally. Results leave over a valid/ready interface, so upstream decode and downstream writeback stall cleanly. Logic ops finish in 1 cycle; MUL uses an iterative shift-add engine of WIDTH cycles. Sits between operand fetch and writeback in processor.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, even)
CNT_W, $clog2(WIDTH)+1, multiply step counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  global clock-enable; low freezes all state
in_valid  in  1  src1/src2/op valid
in_ready  out  1  block can accept an operation this cycle
src1  in  WIDTH  operand A
src2  in  WIDTH  operand B
op  in  4  opcode
out_valid  out  1  result valid
out_ready  in  1  consumer takes result this cycle
result  out  WIDTH  registered result

Behaviour:
- Opcodes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 AND, 0100 OR, 0101 XOR, 0110 SLL (shift by src2[$clog2(WIDTH)-1:0]), 0111 SRL (logical). Codes 1000-1111 are illegal and yield result 0.
- Arithmetic is modulo 2^WIDTH. MUL returns the low WIDTH bits of the unsigned product.
- States:
  - IDLE: no result held.
  - BUSY: MUL iterating.
  - DONE: result held.
- Accept = in_valid && in_ready && enable, sampled on the rising edge of clk.
- in_ready = enable && (state==IDLE || (state==DONE && out_ready)). This allows back-to-back issue with no bubble.
- Non-MUL accept: result is registered at the accept edge; state->DONE. out_valid is high in the next cycle (latency 1).
- MUL accept: operands are latched, counter=WIDTH, state->BUSY.
  - Each enabled cycle does one shift-add step and decrements the counter.
  - When the counter reaches 0: result loads, state->DONE.
  - out_valid rises exactly WIDTH cycles after the accept edge.
- DONE:
  - out_ready=1 without a new accept -> IDLE, out_valid drops next cycle.
  - out_ready=0 -> result and out_valid held stable.
  - Simultaneous out_ready and accept -> the new op replaces the old result.
- BUSY: in_ready=0; out_valid=0.
- enable=0: no state, counter, result or flag changes; in_ready=0; out_valid holds its value.
- Reset (any state, including mid-MUL): state=IDLE, out_valid=0, result=0, counter=0, flags=0. An in-flight MUL is discarded. in_ready returns to 1 (if enable) the cycle after reset deasserts.
- Reset has priority over enable.

Optional Feature:
ALU_FLAGS_EN:
- Defined: adds output port flags[3:0] = {N,Z,C,V}, registered together with result and held with it.
  - N = result[WIDTH-1]; Z = (result==0).
  - C = carry-out of ADD, or of src1+~src2+1 for SUB (1 = no borrow).
  - V = signed overflow for ADD/SUB.
  - C and V are 0 for all other ops; all flags are 0 after reset.
- Undefined: no flags port and no flag logic.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_SRL), state encoding (ST_IDLE, ST_BUSY, ST_DONE), flag bit indices.
- Sub-module alu_mul_iter: shift-add multiplier.
  - Inputs: start, a, b, enable, reset.
  - Outputs: busy, done pulse, product low WIDTH bits.
  - alu_pipe instantiates it and owns the handshake FSM.

Test Plan:
- ADD: WIDTH=32, accept src1=10, src2=5 -> out_valid=1 next cycle, result=15; out_ready=1 -> IDLE.
- SUB / flags: SUB 20,10 -> 10. SUB 5,10 -> 0xFFFFFFFB; with ALU_FLAGS_EN, flags N=1, Z=0, C=0, V=0. ADD 0x7FFFFFFF,1 -> V=1, N=1.
- MUL: accept 5*6 -> in_ready=0 for 32 cycles, out_valid rises exactly 32 cycles after accept, result=30. 0xFFFF*0x10001 -> 0xFFFFFFFF.
- Backpressure: ADD 10+5 with out_ready=0 for 5 cycles -> result=15 and out_valid stable, in_ready=0. Then out_ready=1 plus a new valid SUB 9,4 in the same cycle -> result=5 next cycle, no bubble.
- Reset mid-MUL: assert reset 10 cycles after a MUL accept -> next cycle out_valid=0, result=0, in_ready=1. The aborted product never appears.
- Enable freeze: deassert enable for 4 cycles during MUL 7*3 -> in_ready=0 throughout; out_valid appears 32+4 cycles after accept, result=21. Illegal op 1010 -> result=0, latency 1.
